// File: rtl/keyboard_pkg.sv
// Shared keyboard definitions: UART receiver state encoding, bit-timing helpers
// and the twelve key codes consumed by the LED colour and note stages.
package keyboard_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_freq,
                                             input int unsigned baud);
        return cycles_per_bit(clk_freq, baud) / 2;
    endfunction

    localparam logic [7:0] KEY_Z = 8'h7A;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_X = 8'h78;
    localparam logic [7:0] KEY_D = 8'h64;
    localparam logic [7:0] KEY_C = 8'h63;
    localparam logic [7:0] KEY_V = 8'h76;
    localparam logic [7:0] KEY_G = 8'h67;
    localparam logic [7:0] KEY_B = 8'h62;
    localparam logic [7:0] KEY_H = 8'h68;
    localparam logic [7:0] KEY_N = 8'h6E;
    localparam logic [7:0] KEY_J = 8'h6A;
    localparam logic [7:0] KEY_M = 8'h6D;

endpackage

// File: rtl/uart_key_rx_if.sv
// Held key-code bus from the UART front end to the LED and note stages.
interface uart_key_rx_if;

    logic [7:0] outKey;
    logic       outValid;
    logic       outFrameErr;

    modport master (output outKey, outValid, outFrameErr);
    modport slave  (input  outKey, outValid, outFrameErr);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_key_rx.sv
// 8N1 UART receiver that holds the last received key code on a bus and clears
// it to 0x00 after HOLD_CYCLES of silence (HOLD_CYCLES = 0 holds forever).
module uart_key_rx
    import keyboard_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned HOLD_CYCLES = 10_000_000
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          inRx,
    uart_key_rx_if.master key_if
);

    localparam int unsigned CPB    = cycles_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF   = half_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CPB_LAST    = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST   = CNT_W'(HALF - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);

    logic              rx;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        key_q, key_d;
    logic              valid_q;
    logic              ferr_q;
    logic              accept;
    logic              frame_err;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rstb),
        .d_i   (inRx),
        .q_o   (rx)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            valid_q <= accept;
            ferr_q  <= frame_err;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_WAIT_IDLE: begin
                // Only a full bit time of idle line re-arms start detection.
                if (!rx) begin
                    cnt_d = '0;
                end else if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    state_d = rx ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        frame_err = 1'b0;
        if (state_q == ST_STOP && cnt_q == CPB_LAST) begin
            accept    = rx;
            frame_err = !rx;
        end
    end

    // A reload on the expiry cycle overrides the clear, so the new byte shows.
    always_comb begin
        key_d  = key_q;
        hold_d = hold_q;
        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) key_d = 8'h00;
        end
        if (accept) begin
            key_d  = shift_q;
            hold_d = HOLD_RELOAD;
        end
    end

    assign key_if.outKey      = key_q;
    assign key_if.outValid    = valid_q;
    assign key_if.outFrameErr = ferr_q;

endmodule
